smc777_vram_arbiter: RTL

- Shares the single-port 8-bit video/program RAM between three requesters: ROM/image download loader, CRTC character fetch, and Z80 CPU.
- Sits between the loader, the mc6845 fetch logic, the tv80 bus and the dpram port A.
- Issues one RAM access per clk using fixed priority (download > video > CPU), with a starvation override for the CPU.
- Stalls the CPU through wait_n.

---
 rtl/smc777_pkg.sv | 35 +++
 rtl/smc777_rd_return.sv | 50 +++++
 rtl/smc777_vram_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/smc777_pkg.sv
// Shared types and sizes for the SMC-777 video RAM arbitration logic.
// Grant encoding and the tag that follows each access through the RAM read latency.
package smc777_pkg;

    localparam int VRAM_AW          = 14;
    localparam int VRAM_DW          = 8;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DL,
        GNT_VID,
        GNT_CPU
    } grant_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CPU_RD,
        TAG_CPU_WR
    } rd_tag_t;

    // Downloads never return data, so they collapse to TAG_NONE.
    function automatic rd_tag_t tag_of(input grant_t gnt, input logic cpu_wr);
        rd_tag_t tag;
        tag = TAG_NONE;
        case (gnt)
            GNT_VID: tag = TAG_VID;
            GNT_CPU: tag = cpu_wr ? TAG_CPU_WR : TAG_CPU_RD;
            default: tag = TAG_NONE;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/smc777_rd_return.sv
// Read-return steering: carries each grant's tag two cycles so the RAM data
// arriving a cycle after the registered address is routed to its requester.
import smc777_pkg::*;

module smc777_rd_return #(
    parameter int DW = VRAM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  rd_tag_t       tag_in,
    input  logic [DW-1:0] ram_q,
    output logic          vid_valid,
    output logic [DW-1:0] vid_q,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_dout
);

    rd_tag_t       tag1_q, tag1_d;
    rd_tag_t       tag2_q, tag2_d;
    logic [DW-1:0] vid_hold_q, vid_hold_d;
    logic [DW-1:0] cpu_hold_q, cpu_hold_d;

    // ram_q is passed straight through in the return cycle so the data
    // coincides with its valid pulse; the hold registers keep it afterwards.
    always_comb begin
        tag1_d     = tag_in;
        tag2_d     = tag1_q;
        vid_valid  = (tag2_q == TAG_VID);
        cpu_valid  = (tag2_q == TAG_CPU_RD) || (tag2_q == TAG_CPU_WR);
        vid_q      = vid_valid ? ram_q : vid_hold_q;
        cpu_dout   = (tag2_q == TAG_CPU_RD) ? ram_q : cpu_hold_q;
        vid_hold_d = vid_q;
        cpu_hold_d = cpu_dout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag1_q     <= TAG_NONE;
            tag2_q     <= TAG_NONE;
            vid_hold_q <= '0;
            cpu_hold_q <= '0;
        end else begin
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
            vid_hold_q <= vid_hold_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

endmodule

// File: rtl/smc777_vram_arbiter.sv
// Single-port VRAM arbiter: download > video > CPU, one access per clock,
// with a starvation override that lets a waiting CPU cut in ahead of video.
import smc777_pkg::*;

module smc777_vram_arbiter #(
    parameter int AW           = VRAM_AW,
    parameter int DW           = VRAM_DW,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ready,
    output logic          vid_valid,
    output logic [DW-1:0] vid_q,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ready,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_wait_n,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_q
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    grant_t        grant;
    rd_tag_t       tag;
    logic          cpu_pend_eff;
    logic          cpu_elig;
    logic          starved;

    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q,   ram_we_d;
    logic [DW-1:0] ram_din_q,  ram_din_d;
    logic [SW-1:0] starve_q,   starve_d;
    logic          cpu_pend_q, cpu_pend_d;

    always_comb begin
        // The completing access frees the CPU slot in its own valid cycle.
        cpu_pend_eff = cpu_pend_q & ~cpu_valid;
        cpu_elig     = cpu_req & ~cpu_pend_eff;
        starved      = cpu_elig && (starve_q == STARVE_MAX);

        grant = GNT_NONE;
        if (reset) begin
            grant = GNT_NONE;
        end else if (dl_active) begin
            grant = dl_wr ? GNT_DL : GNT_NONE;
        end else if (starved) begin
            grant = GNT_CPU;
        end else if (vid_req) begin
            grant = GNT_VID;
        end else if (cpu_elig) begin
            grant = GNT_CPU;
        end

        vid_ready  = (grant == GNT_VID);
        cpu_ready  = (grant == GNT_CPU);
        tag        = tag_of(grant, cpu_wr);
        cpu_wait_n = ~((cpu_req | cpu_pend_q) & ~cpu_valid);
    end

    // RAM port registers; an idle cycle keeps the last address on the bus.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_we_d   = 1'b0;
        ram_din_d  = ram_din_q;
        case (grant)
            GNT_DL: begin
                ram_addr_d = dl_addr;
                ram_we_d   = 1'b1;
                ram_din_d  = dl_data;
            end
            GNT_VID: begin
                ram_addr_d = vid_addr;
            end
            GNT_CPU: begin
                ram_addr_d = cpu_addr;
                ram_we_d   = cpu_wr;
                ram_din_d  = cpu_din;
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_pend_d = cpu_pend_q;
        if (cpu_ready) begin
            cpu_pend_d = 1'b1;
        end else if (cpu_valid) begin
            cpu_pend_d = 1'b0;
        end

        // Count is frozen during downloads so the CPU keeps its earned priority.
        starve_d = starve_q;
        if (!dl_active) begin
            if (cpu_ready || !cpu_req) begin
                starve_d = '0;
            end else if (cpu_elig && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
            starve_q   <= '0;
            cpu_pend_q <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_din_q  <= ram_din_d;
            starve_q   <= starve_d;
            cpu_pend_q <= cpu_pend_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_we   = ram_we_q;
    assign ram_din  = ram_din_q;

    smc777_rd_return #(
        .DW (DW)
    ) u_rd_return (
        .clk       (clk),
        .reset     (reset),
        .tag_in    (tag),
        .ram_q     (ram_q),
        .vid_valid (vid_valid),
        .vid_q     (vid_q),
        .cpu_valid (cpu_valid),
        .cpu_dout  (cpu_dout)
    );

endmodule
